// File: rtl/fp_consts.sv
// Shared FP constants plus the scheduler's state and requester-id types.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package fp_consts;

   // IEEE-754 single-precision layout
   localparam int FP_W    = 32;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // Scheduler definitions
   localparam int ID_W  = 1;   // requester index width (two requesters)
   localparam int CNT_W = 4;   // holds EXEC_CYCLES-1 for EXEC_CYCLES up to 15

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/FP_Multiplicator.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the operands.
// Ports: a, b (operands), result (product), overflow (finite result too large -> inf),
//        underflow (nonzero result too small -> signed zero).
module FP_Multiplicator
   import fp_consts::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] result,
   output logic            overflow,
   output logic            underflow
);

   logic              sign;
   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  fa, fb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [47:0]       prod;
   logic [MAN_W-1:0]  mant;
   logic              guard, sticky, norm, round_up;
   logic [MAN_W:0]    mant_r;
   logic [9:0]        exp_raw;
   logic [9:0]        exp_sum;

   assign sign = a[31] ^ b[31];
   assign ea   = a[30:23];
   assign eb   = b[30:23];
   assign fa   = a[22:0];
   assign fb   = b[22:0];

   // Subnormal inputs are treated as zero.
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_MAX) && (fa == '0);
   assign b_inf  = (eb == EXP_MAX) && (fb == '0);
   assign a_nan  = (ea == EXP_MAX) && (fa != '0);
   assign b_nan  = (eb == EXP_MAX) && (fb != '0);

   assign prod = 48'({1'b1, fa}) * 48'({1'b1, fb});

   always_comb begin
      norm     = prod[47];
      mant     = '0;
      guard    = 1'b0;
      sticky   = 1'b0;
      if (prod[47]) begin
         mant   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         mant   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      round_up = guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
      // Exponent kept in an offset form (true biased exponent + 127) so no signed math is needed.
      exp_raw  = {2'b00, ea} + {2'b00, eb};
      exp_sum  = exp_raw + {9'd0, norm} + {9'd0, mant_r[MAN_W]};
   end

   always_comb begin
      result    = '0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         result = FP_QNAN;
      end else if (a_inf || b_inf) begin
         result = {sign, EXP_MAX, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         result = {sign, {(FP_W-1){1'b0}}};
      end else if (exp_sum >= 10'(EXP_BIAS + 255)) begin
         result   = {sign, EXP_MAX, {MAN_W{1'b0}}};
         overflow = 1'b1;
      end else if (exp_sum <= 10'(EXP_BIAS)) begin
         result    = {sign, {(FP_W-1){1'b0}}};
         underflow = 1'b1;
      end else begin
         // A rounding carry leaves mant_r[22:0] at zero, which is the correct mantissa.
         result = {sign, 8'(exp_sum - 10'(EXP_BIAS)), mant_r[MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/fp_mult_scheduler.sv
// Two-requester round-robin front end for a single FP multiplier, one operation in flight.
// Latency: accept in cycle T -> resp_valid in cycle T+EXEC_CYCLES+1.
// Backpressure: while a result waits for resp_ready both reqN_ready stay low.
// Ports: clk, reset (async, active-high); req0/req1 valid/ready/a/b; resp valid/ready/id/result;
//        resp_overflow/resp_underflow per result; flags_sticky {ovf,unf} with flags_clear.
module fp_mult_scheduler
   import fp_consts::*;
#(
   parameter int EXEC_CYCLES = 1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [FP_W-1:0] req0_a,
   input  logic [FP_W-1:0] req0_b,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [FP_W-1:0] req1_a,
   input  logic [FP_W-1:0] req1_b,
   output logic            req1_ready,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic [FP_W-1:0] resp_result,
   output logic            resp_overflow,
   output logic            resp_underflow,
   output logic [1:0]      flags_sticky,
   input  logic            flags_clear
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

   sched_state_t     state_q, state_d;
   logic [ID_W-1:0]  last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FP_W-1:0]  op_a_q, op_a_d;
   logic [FP_W-1:0]  op_b_q, op_b_d;
   logic [ID_W-1:0]  op_id_q, op_id_d;
   logic [ID_W-1:0]  resp_id_q, resp_id_d;
   logic [FP_W-1:0]  resp_result_q, resp_result_d;
   logic             resp_ovf_q, resp_ovf_d;
   logic             resp_unf_q, resp_unf_d;
   logic [1:0]       flags_q, flags_d;
   logic             capture;

   logic [FP_W-1:0]  mul_result;
   logic             mul_ovf, mul_unf;

   // The multiplier only ever sees the latched operands.
   FP_Multiplicator u_mul (
      .a         (op_a_q),
      .b         (op_b_q),
      .result    (mul_result),
      .overflow  (mul_ovf),
      .underflow (mul_unf)
   );

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      op_id_d       = op_id_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_ovf_d    = resp_ovf_q;
      resp_unf_d    = resp_unf_q;
      flags_d       = flags_q;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      capture       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // On a tie port 0 wins only if port 1 had the previous grant.
            if (req0_valid && (!req1_valid || (last_grant_q == ID_W'(1)))) begin
               req0_ready   = 1'b1;
               op_a_d       = req0_a;
               op_b_d       = req0_b;
               op_id_d      = ID_W'(0);
               last_grant_d = ID_W'(0);
               cnt_d        = CNT_INIT;
               state_d      = ST_EXEC;
            end else if (req1_valid) begin
               req1_ready   = 1'b1;
               op_a_d       = req1_a;
               op_b_d       = req1_b;
               op_id_d      = ID_W'(1);
               last_grant_d = ID_W'(1);
               cnt_d        = CNT_INIT;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               capture       = 1'b1;
               resp_result_d = mul_result;
               resp_ovf_d    = mul_ovf;
               resp_unf_d    = mul_unf;
               resp_id_d     = op_id_q;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            // Returning to IDLE takes a cycle, so no grant overlaps the response handshake.
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Clear first, then OR in new flags: a simultaneous capture survives the clear.
      if (flags_clear) begin
         flags_d = 2'b00;
      end
      if (capture) begin
         flags_d = flags_d | {mul_ovf, mul_unf};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= ID_W'(1);
         cnt_q         <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         op_id_q       <= '0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
         resp_ovf_q    <= 1'b0;
         resp_unf_q    <= 1'b0;
         flags_q       <= 2'b00;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         op_id_q       <= op_id_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_ovf_q    <= resp_ovf_d;
         resp_unf_q    <= resp_unf_d;
         flags_q       <= flags_d;
      end
   end

   assign resp_valid     = (state_q == ST_DONE);
   assign resp_id        = resp_id_q;
   assign resp_result    = resp_result_q;
   assign resp_overflow  = resp_ovf_q;
   assign resp_underflow = resp_unf_q;
   assign flags_sticky   = flags_q;

endmodule
